// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver:
// conversion FSM states, active-high segment glyphs, overflow threshold helper.
package seg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } conv_state_t;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-high seven-segment pattern {g..a}; 10..15 decode blank.
// Ports: nib (BCD digit in), seg (segment pattern out).
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_bcd_n.sv
// N-digit multiplexed seven-segment driver with double-dabble BCD conversion,
// leading-zero blanking, per-digit DP, overflow dash display and scan dead time.
// Ports: Sys_CLK, Sys_RST (async low), Data_Bin/Load (value strobe), EN,
//        Blank_Lead, DP_Mask (per digit), COM (digit select), SEG {dp,g..a},
//        Busy (conversion running), Overflow (value above 10^DIGITS-1).
module seg_scan_bcd_n
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter bit COM_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST,
    input  logic [BIN_W-1:0]  Data_Bin,
    input  logic              Load,
    input  logic              EN,
    input  logic              Blank_Lead,
    input  logic [DIGITS-1:0] DP_Mask,
    output logic [DIGITS-1:0] COM,
    output logic [7:0]        SEG,
    output logic              Busy,
    output logic              Overflow
);

    localparam int ACC_N = DIGITS + 1;
    localparam int ACC_W = 4 * ACC_N;
    localparam int DSP_W = 4 * DIGITS;
    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int PS_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned LIMIT = pow10(DIGITS) - 1;

    localparam logic [DIGITS-1:0] COM_OFF = {DIGITS{COM_ACT_LOW}};
    localparam logic [7:0]        SEG_OFF = {8{SEG_ACT_LOW}};

    // ---------------- conversion ----------------
    conv_state_t      state;
    conv_state_t      state_nxt;
    logic [BIN_W-1:0] sh;
    logic [BIN_W-1:0] cap;
    logic [BIN_W-1:0] pend_val;
    logic [BIN_W-1:0] next_val;
    logic             pend;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_shift;
    logic [CNT_W-1:0] cnt;
    logic [DSP_W-1:0] disp;
    logic             busy_q;
    logic             ovf_q;

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Load) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CNT_W'(BIN_W - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = (pend || Load) ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Double-dabble step: correct every nibble >= 5, then shift in the MSB
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < ACC_N; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_shift = (acc_adj << 1) | ACC_W'(sh[BIN_W-1]);
    end

    // A strobe in the DONE cycle is newer than any held pending value
    assign next_val = Load ? Data_Bin : pend_val;

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            sh       <= '0;
            cap      <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            disp     <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Load) begin
                        sh     <= Data_Bin;
                        cap    <= Data_Bin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    sh  <= sh << 1;
                    acc <= acc_shift;
                    cnt <= cnt + 1'b1;
                    if (Load) begin
                        pend_val <= Data_Bin;
                        pend     <= 1'b1;
                    end
                end
                S_DONE: begin
                    disp  <= acc[DSP_W-1:0];
                    ovf_q <= 64'(cap) > LIMIT;
                    if (pend || Load) begin
                        sh   <= next_val;
                        cap  <= next_val;
                        acc  <= '0;
                        cnt  <= '0;
                        pend <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Overflow = ovf_q;

    // ---------------- scan ----------------
    logic [PS_W-1:0]   ps;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic              tc;
    logic [DIGITS:0]   lz;
    logic [3:0]        nib;
    logic              dp_sel;
    logic              lz_sel;
    logic              blank_z;
    logic [6:0]        glyph;
    logic [7:0]        seg_hi;
    logic [DIGITS-1:0] com_hi;
    logic [DIGITS-1:0] com_q;
    logic [7:0]        seg_q;

    assign tc = (ps == PS_W'(DWELL - 1));

    always_comb begin
        idx_nxt = idx;
        if (tc) begin
            idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // lz[i]: digits i..DIGITS-1 are all zero
    always_comb begin
        lz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz[i] = lz[i+1] & (disp[4*i +: 4] == 4'd0);
        end
    end

    // SEG follows the index being entered so it switches with the index
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nib    = disp[4*i +: 4];
                dp_sel = DP_Mask[i];
                lz_sel = lz[i];
            end
        end
    end

    seg7_decode u_dec (
        .nib (nib),
        .seg (glyph)
    );

    always_comb begin
        blank_z = Blank_Lead && (idx_nxt != '0) && lz_sel;
        seg_hi  = '0;
        if (EN) begin
            seg_hi[7] = dp_sel;
            if (ovf_q) begin
                seg_hi[6:0] = SEG_DASH;
            end else if (blank_z) begin
                seg_hi[6:0] = SEG_BLANK;
            end else begin
                seg_hi[6:0] = glyph;
            end
        end
    end

    // Index change cycle doubles as dead time: COM stays off for that cycle
    always_comb begin
        com_hi = '0;
        if (EN && !tc) begin
            com_hi = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            ps    <= '0;
            idx   <= '0;
            com_q <= COM_OFF;
            seg_q <= SEG_OFF;
        end else begin
            ps    <= tc ? '0 : ps + 1'b1;
            idx   <= idx_nxt;
            com_q <= com_hi ^ COM_OFF;
            seg_q <= seg_hi ^ SEG_OFF;
        end
    end

    assign COM = com_q;
    assign SEG = seg_q;

endmodule

// File: doc/seg_scan_bcd_n.md
Name: seg_scan_bcd_n

Overview:
- Parametrised N-digit multiplexed seven-segment driver; next generation of the 2-digit nixie-tube driver.
- Converts a binary sample to BCD with a sequential double-dabble engine and supports leading-zero blanking, per-digit decimal points, an overflow indication, and dead-time between digit switches.
- Sits between data producers (AD converter BCD path, UART receive value, counters) and the board COM/SEG pins in the test top.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8)
- BIN_W, 14, Data_Bin width; 2^BIN_W may exceed 10^DIGITS, which is handled by overflow
- CLK_HZ, 50000000, Sys_CLK frequency
- SCAN_HZ, 1000, per-digit dwell rate; dwell = CLK_HZ/SCAN_HZ cycles
- COM_ACT_LOW, 1, 1 = COM lines active-low
- SEG_ACT_LOW, 1, 1 = SEG lines active-low

Ports:
- Sys_CLK  in  1  system clock
- Sys_RST  in  1  asynchronous reset, active-low
- Data_Bin  in  BIN_W  unsigned value to display
- Load  in  1  single-cycle strobe; capture Data_Bin
- EN  in  1  0 = display dark; scanning continues
- Blank_Lead  in  1  1 = blank leading zeros
- DP_Mask  in  DIGITS  per-digit decimal point; bit i maps to digit i (0 = least significant)
- COM  out  DIGITS  one-hot digit select
- SEG  out  8  {dp,g,f,e,d,c,b,a}
- Busy  out  1  conversion in progress
- Overflow  out  1  last accepted value exceeded 10^DIGITS-1

Behaviour:
- Reset (async, Sys_RST=0):
  - COM = all inactive; SEG = all segments off (8'hFF when SEG_ACT_LOW=1).
  - Busy=0, Overflow=0; display BCD registers = 0; digit index = 0; prescaler = 0; pending flag = 0; FSM = IDLE.
- Conversion FSM:
  - IDLE: Load=1 captures Data_Bin into the shift register, clears the BCD accumulator, sets Busy and enters SHIFT.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left 1 with the binary MSB shifted in. After the BIN_W-th cycle, go to DONE.
  - DONE: one cycle. Copy the accumulator into the display registers and set Overflow = (captured value > 10^DIGITS-1). Clear Busy if there is no pending load; otherwise return to SHIFT with the pending value.
  - Latency: Load at cycle 0 → display registers updated, Busy=0, at the end of cycle BIN_W+1.
  - Load while Busy: Data_Bin is captured into the pending register and the pending flag is set. The latest Load wins, and the running conversion completes undisturbed.
  - Load in the same cycle as DONE: treated as pending, so it is converted next.
  - The accumulator holds DIGITS+1 nibbles internally so an overflowing value never corrupts the shift.
- Scan:
  - The prescaler counts 0..CLK_HZ/SCAN_HZ-1. At terminal count, the digit index advances, wrapping from DIGITS-1 to 0.
  - Dead time: in the first cycle after each index change, COM is all inactive.
  - COM drives only bit [index] active, and only when EN=1. SEG is registered and changes in the same cycle as the index.
- Digit content:
  - Overflow=1: every digit shows '-' (segment g only). DP is still applied from DP_Mask.
  - Blank_Lead=1: digit i>0 is blank if digits i..DIGITS-1 are all zero. Digit 0 is never blanked. DP still shows on a blanked digit.
  - Nibble values 10..15 are unreachable; they decode to blank.
  - EN=0: SEG all off and COM all inactive. Conversion and scanning continue.
- Polarity: outputs are inverted at the final register per COM_ACT_LOW / SEG_ACT_LOW.
- Reset mid-conversion: aborts immediately; pending is discarded; display returns to 0.

Decomposition:
- Shared package (seg_pkg):
  - FSM state encoding (IDLE, SHIFT, DONE)
  - Segment constants (SEG_DASH, SEG_BLANK, glyphs for 0..9)
  - Constant function pow10(DIGITS) for the overflow threshold
- One sub-module: seg7_decode (combinational nibble → 7-segment, active-high), instantiated once on the selected nibble.

Test Plan:
All scenarios use DIGITS=4, BIN_W=14, CLK_HZ=1000, SCAN_HZ=100 (dwell 10 cycles), active-low outputs.
- Reset then idle:
  - COM=4'hF, SEG=8'hFF, Busy=0 during reset.
  - After release, digit 0 shows '0' (SEG=8'hC0); digits 1..3 show '0' when Blank_Lead=0.
- Load Data_Bin=1234 with Blank_Lead=0:
  - Busy high for cycles 1..15; display updates at cycle 15.
  - The scan shows 4,3,2,1 on COM=1110,1101,1011,0111, with 1 dead cycle between digits.
- Load 7 with Blank_Lead=1, DP_Mask=4'b0010:
  - Digits 3 and 2 are dark (SEG=8'hFF).
  - Digit 1 shows dp only (8'h7F); digit 0 shows '7' (8'hF8).
- Load 12000:
  - Overflow=1; all digits show '-' (8'hBF).
  - A following Load of 5 clears Overflow; the display reads 0005.
- Load 100, then Load 200 and Load 300 while Busy:
  - 100 displays first, then 300; 200 is never displayed.
  - Busy stays high continuously until 300 is done.
- Sys_RST asserted mid-SHIFT, then EN=0:
  - Immediate reset values on COM and SEG.
  - With EN=0 after release, COM stays 4'hF, yet a Load still completes and Busy falls at cycle 15.
